// File: rtl/counter_74xx_pkg.sv
// counter_74xx_pkg
//   Shared constants for the 74xx-class counter models: default HC-family
//   propagation delays (ns) and the widest counter chain the models support.
//   No ports.
`timescale 1ns/1ps
package counter_74xx_pkg;

  localparam int TPD_CLR_HC    = 17;
  localparam int TPD_CNT_HC    = 10;
  localparam int TPD_LOAD_HC   = 15;
  localparam int CNT_MAX_WIDTH = 32;

endpackage

// File: rtl/ripple_counter_stage.sv
// ripple_counter_stage
//   One toggle stage of a ripple counter: T flip-flop with asynchronous clear,
//   asynchronous transparent load and a selectable trigger edge.
//   Optional macro RIPPLE_COUNTER_TIMING_EN adds the TPD_* output delays.
// Ports:
//   trig      in   trigger input (gated clock for stage 0, predecessor q otherwise)
//   fall_edge in   1: toggle on falling trig, 0: toggle on rising trig
//   clr       in   asynchronous clear, active-high, dominant
//   load_n    in   asynchronous transparent load, active-low
//   d         in   load data bit
//   q         out  stage output
`timescale 1ns/1ps
module ripple_counter_stage
  import counter_74xx_pkg::*;
#(
  parameter int TPD_CLR  = TPD_CLR_HC,
  parameter int TPD_CNT  = TPD_CNT_HC,
  parameter int TPD_LOAD = TPD_LOAD_HC
) (
  input  logic trig,
  input  logic fall_edge,
  input  logic clr,
  input  logic load_n,
  input  logic d,
  output logic q
);

  // The stage value is split into a latched base (cleared or loaded value)
  // and a toggle parity. Clear/load hold the parity at zero, so when they
  // release the output simply keeps the base without needing a capture edge.
  logic hold;
  logic base;
  logic tog;

  assign hold = clr | ~load_n;

`ifdef RIPPLE_COUNTER_TIMING_EN
  always_latch begin
    if (clr)
      base <= #TPD_CLR 1'b0;
    else if (!load_n)
      base <= #TPD_LOAD d;
  end

  // Both trig edges wake the block; the current trig level tells which edge
  // it was, so a direction change alone never produces a toggle.
  always_ff @(posedge trig or negedge trig or posedge hold) begin
    if (hold) begin
      if (clr)
        tog <= #TPD_CLR 1'b0;
      else
        tog <= #TPD_LOAD 1'b0;
    end else if (trig != fall_edge) begin
      tog <= #TPD_CNT ~tog;
    end
  end
`else
  always_latch begin
    if (clr)
      base <= 1'b0;
    else if (!load_n)
      base <= d;
  end

  always_ff @(posedge trig or negedge trig or posedge hold) begin
    if (hold)
      tog <= 1'b0;
    else if (trig != fall_edge)
      tog <= ~tog;
  end

  // Delays are accepted but ignored so both builds share one interface.
  if (TPD_CLR == 0 && TPD_CNT == 0 && TPD_LOAD == 0) begin : g_delays_ignored
  end
`endif

  assign q = base ^ tog;

endmodule

// File: rtl/ripple_counter_updown_n.sv
// ripple_counter_updown_n
//   WIDTH-stage asynchronous up/down ripple counter with count enable,
//   asynchronous parallel load and 74193-style carry/borrow outputs.
//   Optional macro RIPPLE_COUNTER_TIMING_EN selects the timed model
//   (TPD_* delays, ripple accumulating per stage); default is zero-delay.
// Ports:
//   ripple_clock in   count clock, stage 0 toggles on its falling edge
//   clr          in   asynchronous clear, active-high, dominant
//   load_n       in   asynchronous transparent parallel load, active-low
//   d            in   [WIDTH] load data
//   up           in   1 = count up, 0 = count down
//   en_n         in   count enable, active-low (gates stage 0 only)
//   q            out  [WIDTH] counter value
//   tc_up_n      out  carry: low when q all ones, up=1, ripple_clock low
//   tc_dn_n      out  borrow: low when q all zeros, up=0, ripple_clock low
`timescale 1ns/1ps
module ripple_counter_updown_n
  import counter_74xx_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int TPD_CLR  = TPD_CLR_HC,
  parameter int TPD_CNT  = TPD_CNT_HC,
  parameter int TPD_LOAD = TPD_LOAD_HC
) (
  input  logic             ripple_clock,
  input  logic             clr,
  input  logic             load_n,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  input  logic             en_n,
  output logic [WIDTH-1:0] q,
  output logic             tc_up_n,
  output logic             tc_dn_n
);

  // en_n only changes while the clock is high, so OR-gating keeps the stage 0
  // clock high while disabled and falling edges in that window are dropped.
  logic stage0_clk;
  assign stage0_clk = ripple_clock | en_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic trig;
    logic fall_edge;

    if (i == 0) begin : g_first
      assign trig      = stage0_clk;
      assign fall_edge = 1'b1;
    end else begin : g_chain
      // Up: toggle when the predecessor falls (1->0 carry).
      // Down: toggle when it rises (0->1 borrow).
      assign trig      = q[i-1];
      assign fall_edge = up;
    end

    ripple_counter_stage #(
      .TPD_CLR  (TPD_CLR),
      .TPD_CNT  (TPD_CNT),
      .TPD_LOAD (TPD_LOAD)
    ) u_stage (
      .trig      (trig),
      .fall_edge (fall_edge),
      .clr       (clr),
      .load_n    (load_n),
      .d         (d[i]),
      .q         (q[i])
    );
  end

  assign tc_up_n = ~(up  & ~ripple_clock &  (&q));
  assign tc_dn_n = ~(~up & ~ripple_clock & ~(|q));

endmodule

// File: tb/tb_ripple_counter_updown_n.sv
`timescale 1ns/1ps
module tb_ripple_counter_updown_n;
  import counter_74xx_pkg::*;

  localparam int W    = 12;
  localparam int MASK = (1 << W) - 1;
`ifdef RIPPLE_COUNTER_TIMING_EN
  localparam int SETTLE     = W * TPD_CNT_HC + 5;
  localparam int ASYNC_WAIT = 20;
`else
  localparam int SETTLE     = 1;
  localparam int ASYNC_WAIT = 1;
`endif

  logic         ripple_clock = 1'b1;
  logic         clr          = 1'b1;
  logic         load_n       = 1'b1;
  logic         up           = 1'b1;
  logic         en_n         = 1'b0;
  logic [W-1:0] d            = '0;
  logic [W-1:0] q;
  logic         tc_up_n;
  logic         tc_dn_n;

  int n_tests = 0;
  int n_fail  = 0;
  int model_q = 0;

  ripple_counter_updown_n #(.WIDTH(W)) dut (
    .ripple_clock (ripple_clock),
    .clr          (clr),
    .load_n       (load_n),
    .d            (d),
    .up           (up),
    .en_n         (en_n),
    .q            (q),
    .tc_up_n      (tc_up_n),
    .tc_dn_n      (tc_dn_n)
  );

  always #200 ripple_clock = ~ripple_clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_tc_up(input bit clk_lvl);
    return (up && !clk_lvl && model_q == MASK) ? 0 : 1;
  endfunction

  function automatic int exp_tc_dn(input bit clk_lvl);
    return (!up && !clk_lvl && model_q == 0) ? 0 : 1;
  endfunction

  // Called while the clock is high after changing clr/load_n/d.
  task automatic apply_async();
    if (clr)
      model_q = 0;
    else if (!load_n)
      model_q = int'(d);
    #ASYNC_WAIT;
    chk("async_q", 32'(q), model_q);
  endtask

  // One full clock: falling edge, settle, check; rising edge, check; return
  // with the clock high and ripple settled so inputs may change.
  task automatic edge_step();
    @(negedge ripple_clock);
    if (clr)
      model_q = 0;
    else if (!load_n)
      model_q = int'(d);
    else if (!en_n)
      model_q = up ? ((model_q + 1) & MASK) : ((model_q - 1) & MASK);
    #SETTLE;
    chk("q_low", 32'(q), model_q);
    chk("tc_up_low", 32'(tc_up_n), exp_tc_up(1'b0));
    chk("tc_dn_low", 32'(tc_dn_n), exp_tc_dn(1'b0));
    @(posedge ripple_clock);
    #1;
    chk("tc_up_high", 32'(tc_up_n), exp_tc_up(1'b1));
    chk("tc_dn_high", 32'(tc_dn_n), exp_tc_dn(1'b1));
    #19;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_carry;
    int seen_borrow;
    int r;
    int exp_dn[4];
    exp_dn = '{2, 1, 0, MASK};

    // Reset state and a clock edge while clr is held.
    #20;
    chk("reset_q", 32'(q), 0);
    chk("reset_tc_up", 32'(tc_up_n), 1);
    chk("reset_tc_dn", 32'(tc_dn_n), 1);
    edge_step();

    // Load 0xA5A, then clr pulse clears it.
    clr = 1'b0; load_n = 1'b0; d = 12'hA5A;
    apply_async();
    load_n = 1'b1;
    #1;
    clr = 1'b1;
    model_q = 0;
`ifdef RIPPLE_COUNTER_TIMING_EN
    #(TPD_CLR_HC - 2);
    chk("clr_before_tpd", 32'(q), 32'h0A5A);
    #4;
`else
    #1;
`endif
    chk("clr_q", 32'(q), 0);
    chk("clr_tc_up", 32'(tc_up_n), 1);
    edge_step();
    clr = 1'b0;
    #1;

    // Count up through a full wrap of 4096 edges.
    up = 1'b1; en_n = 1'b0;
    seen_carry = 0;
    for (int i = 0; i < 4096; i++) begin
      edge_step();
      if (model_q == MASK) seen_carry++;
    end
    chk("wrap_q", 32'(q), 0);
    chk("carry_seen", 32'(seen_carry), 1);

    // Ripple settle on 0x7FF -> 0x800.
    load_n = 1'b0; d = 12'h7FF;
    apply_async();
    load_n = 1'b1;
    @(negedge ripple_clock);
    model_q = 12'h800;
`ifdef RIPPLE_COUNTER_TIMING_EN
    #(W * TPD_CNT_HC - 5);
    chk("ripple_msb_early", 32'(q[W-1]), 0);
    #10;
    chk("ripple_settled", 32'(q), 32'h800);
`else
    #1;
    chk("zero_settle", 32'(q), 32'h800);
`endif
    @(posedge ripple_clock);
    #20;

    // Count down from 3 through zero.
    load_n = 1'b0; d = 12'h003;
    apply_async();
    load_n = 1'b1; up = 1'b0;
    seen_borrow = 0;
    for (int i = 0; i < 4; i++) begin
      edge_step();
      chk("down_seq", 32'(q), exp_dn[i]);
      if (model_q == 0) seen_borrow++;
    end
    chk("borrow_seen", 32'(seen_borrow), 1);

    // Load priority over clock, clr over load, clr release into load.
    up = 1'b1;
    load_n = 1'b0; d = 12'h123;
    apply_async();
    repeat (5) edge_step();
    chk("load_hold", 32'(q), 32'h123);
    clr = 1'b1;
    apply_async();
    chk("clr_over_load", 32'(q), 0);
    clr = 1'b0;
    apply_async();
    chk("clr_release_load", 32'(q), 32'h123);
    load_n = 1'b1;

    // Enable: edges lost while disabled, exactly one count after.
    en_n = 1'b1;
    repeat (10) edge_step();
    chk("en_hold", 32'(q), 32'h123);
    en_n = 1'b0;
    edge_step();
    chk("en_resume", 32'(q), 32'h124);

    // Randomized mix of direction, enable, load and clear.
    for (int i = 0; i < 400; i++) begin
      up   = 1'($urandom_range(0, 1));
      en_n = ($urandom_range(0, 3) == 0);
      r    = int'($urandom_range(0, 15));
      clr    = (r == 0);
      load_n = !(r == 1 || r == 2);
      d      = 12'($urandom);
      apply_async();
      edge_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
